// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output/direction registers, synchronised inputs and
// per-pin edge-triggered interrupts with write-one-to-clear pending bits.
module gpio_ctrl #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [3:0]       wen,
  input  logic [5:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [3:0] {
    AddrOut  = 4'h0,
    AddrDir  = 4'h1,
    AddrIn   = 4'h2,
    AddrSet  = 4'h3,
    AddrClr  = 4'h4,
    AddrTgl  = 4'h5,
    AddrIe   = 4'h6,
    AddrEdge = 4'h7,
    AddrPend = 4'h8
  } reg_addr_e;

  localparam int unsigned WarmCycles = SYNC_STAGES + 1;
  localparam int unsigned WarmW      = $clog2(WarmCycles + 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WarmW-1:0] warm_q;

  logic             wr_en, rd_en, warm_done;
  logic [31:0]      byte_mask;
  logic [WIDTH-1:0] wbits, in_sync, rise, fall, pend_set;
  reg_addr_e        reg_sel;
  logic             unused_bits;

  assign wr_en     = sel && (wen != 4'b0000);
  assign rd_en     = sel && (wen == 4'b0000);
  assign reg_sel   = reg_addr_e'(addr[5:2]);
  assign byte_mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  // Byte enables and the pin count together bound which bits a write may touch.
  assign wbits     = wdata[WIDTH-1:0] & byte_mask[WIDTH-1:0];

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign rise      = in_sync & ~prev_q;
  assign fall      = ~in_sync & prev_q;
  assign warm_done = (warm_q == WarmW'(WarmCycles));
  assign pend_set  = ((rise & edge_sel_q) | (fall & ~edge_sel_q)) & ie_q & {WIDTH{warm_done}};

  assign unused_bits = ^{addr[1:0], wdata, byte_mask};

  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    ie_d       = ie_q;
    edge_sel_d = edge_sel_q;
    pend_d     = pend_q;
    if (wr_en) begin
      case (reg_sel)
        AddrOut:  out_d      = (out_q & ~byte_mask[WIDTH-1:0]) | wbits;
        AddrDir:  dir_d      = (dir_q & ~byte_mask[WIDTH-1:0]) | wbits;
        AddrSet:  out_d      = out_q | wbits;
        AddrClr:  out_d      = out_q & ~wbits;
        AddrTgl:  out_d      = out_q ^ wbits;
        AddrIe:   ie_d       = (ie_q & ~byte_mask[WIDTH-1:0]) | wbits;
        AddrEdge: edge_sel_d = (edge_sel_q & ~byte_mask[WIDTH-1:0]) | wbits;
        AddrPend: pend_d     = pend_q & ~wbits;
        default:  ;
      endcase
    end
    // A hardware set lands after the clear so it wins a same-cycle collision.
    pend_d = pend_d | pend_set;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (reg_sel)
        AddrOut:  rdata_d[WIDTH-1:0] = out_q;
        AddrDir:  rdata_d[WIDTH-1:0] = dir_q;
        AddrIn:   rdata_d[WIDTH-1:0] = in_sync;
        AddrIe:   rdata_d[WIDTH-1:0] = ie_q;
        AddrEdge: rdata_d[WIDTH-1:0] = edge_sel_q;
        AddrPend: rdata_d[WIDTH-1:0] = pend_q;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      dir_q      <= '0;
      ie_q       <= '0;
      edge_sel_q <= '0;
      pend_q     <= '0;
      rdata_q    <= '0;
      prev_q     <= '0;
      warm_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      ie_q       <= ie_d;
      edge_sel_q <= edge_sel_d;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
      prev_q     <= in_sync;
      if (!warm_done) warm_q <= warm_q + 1'b1;
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rdata    = rdata_q;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(pend_q & ie_q);

endmodule
